mor1kx_rf_arbiter_marocchino: RTL and testbench

MOR1KX_RF_ARBITER_MAROCCHINO -- requirements
Module: mor1kx_rf_arbiter_marocchino

---
 rtl/mor1kx_marocchino_pkg.sv | 21 ++
 rtl/mor1kx_sat_counter.sv | 52 +++++
 rtl/mor1kx_rf_arbiter_marocchino.sv | 198 +++++++++++++++++++
 tb/tb_mor1kx_rf_arbiter_marocchino.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_marocchino_pkg.sv
// Shared definitions for the MAROCCHINO register-file arbiter.
//   rf_arb_state_t : arbiter FSM state encodings (INIT, IDLE, RD, ACK)
//   SPR_GRP_GPR    : SPR group number of the GPR access window
//   is_gpr_spr()   : true when a 16-bit SPR address falls in the GPR group
package mor1kx_marocchino_pkg;

  typedef enum logic [1:0] {
    ARB_INIT = 2'd0,
    ARB_IDLE = 2'd1,
    ARB_RD   = 2'd2,
    ARB_ACK  = 2'd3
  } rf_arb_state_t;

  localparam logic [6:0] SPR_GRP_GPR = 7'h2;

  // SPR group lives in the top seven address bits
  function automatic logic is_gpr_spr(input logic [15:0] addr);
    return (addr[15:9] == SPR_GRP_GPR);
  endfunction

endpackage

// File: rtl/mor1kx_sat_counter.sv
// Saturating up-counter with synchronous clear, used to measure how long an
// SPR access has been blocked by write-back traffic.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one more cycle (ignored once saturated)
//   clr      : clear to zero (wins over inc)
//   sat      : registered flag, high while the count equals LIMIT
module mor1kx_sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             sat_r;

  // next count: clear first, then increment until LIMIT is reached
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = {WIDTH{1'b0}};
    end else if (inc && (count_r != LIMIT_W)) begin
      count_nxt_s = count_r + ONE_W;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // count and saturation flag registers; flag tracks the next count so it
  // rises in the same cycle the count reaches LIMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
      sat_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      sat_r   <= (count_nxt_s == LIMIT_W);
    end
  end

  assign sat = sat_r;

endmodule

// File: rtl/mor1kx_rf_arbiter_marocchino.sv
// Register-file write-port arbiter for MAROCCHINO. Shares the RF write port
// between pipeline write-back (always highest priority) and SPR-bus accesses
// to the GPR window (SPR group 2). SPR reads go to a separate SPR-side RF copy.
// A starved SPR access eventually raises pipe_hold_o so write-back drains.
// Optional build macro MOR1KX_RF_INIT_CLEAR_EN: after reset, clear every RF
// entry to zero (one per cycle) before serving any access.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   wb_we_i/wb_waddr_i/wb_wdata_i     : pipeline write-back
//   spr_bus_addr_i/stb_i/we_i/dat_i   : SPR bus request
//   spr_gpr_ack_o/spr_gpr_dat_o       : SPR GPR-window response
//   rf_we_o/rf_waddr_o/rf_wdata_o     : RF write port
//   rf_spr_re_o/rf_spr_raddr_o        : SPR-side RF read request
//   rf_spr_rdat_i                     : SPR-side read data (one cycle later)
//   pipe_hold_o                       : freeze write-back request
//   init_busy_o                       : RF clear sequence running
module mor1kx_rf_arbiter_marocchino
  import mor1kx_marocchino_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int RF_ADDR_WIDTH        = 5,
  parameter int STARVE_LIMIT         = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_we_i,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_waddr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wb_wdata_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  output logic                            rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_waddr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wdata_o,
  output logic                            rf_spr_re_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_spr_raddr_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_spr_rdat_i,
  output logic                            pipe_hold_o,
  output logic                            init_busy_o
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [RF_ADDR_WIDTH-1:0]        ADDR_ZERO = {RF_ADDR_WIDTH{1'b0}};
  localparam logic [OPTION_OPERAND_WIDTH-1:0] DATA_ZERO = {OPTION_OPERAND_WIDTH{1'b0}};

`ifdef MOR1KX_RF_INIT_CLEAR_EN
  localparam rf_arb_state_t RESET_STATE = ARB_INIT;
`else
  localparam rf_arb_state_t RESET_STATE = ARB_IDLE;
`endif

  rf_arb_state_t                   state_r;
  rf_arb_state_t                   state_nxt_s;
  logic [OPTION_OPERAND_WIDTH-1:0] data_r;
  logic                            gpr_hit_s;
  logic [RF_ADDR_WIDTH-1:0]        spr_rf_addr_s;
  logic                            grant_s;
  logic                            blocked_s;
  logic                            init_active_s;
  logic                            init_last_s;
  logic [RF_ADDR_WIDTH-1:0]        init_addr_s;
  logic                            starve_sat_s;
  logic                            unused_addr_s;

  assign gpr_hit_s     = spr_bus_stb_i && is_gpr_spr(spr_bus_addr_i);
  assign spr_rf_addr_s = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
  // address bits between the RF index and the group field are don't-care
  assign unused_addr_s = &{1'b0, spr_bus_addr_i[8:RF_ADDR_WIDTH]};

  // SPR wins the port only when write-back is silent this cycle
  assign grant_s   = !rst && (state_r == ARB_IDLE) && gpr_hit_s && !wb_we_i;
  assign blocked_s = !rst && (state_r == ARB_IDLE) && gpr_hit_s &&  wb_we_i;

`ifdef MOR1KX_RF_INIT_CLEAR_EN
  logic [RF_ADDR_WIDTH-1:0] init_cnt_r;

  // clear-sequence address; restarts from zero on every reset
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_r <= ADDR_ZERO;
    end else if (state_r == ARB_INIT) begin
      init_cnt_r <= init_cnt_r + RF_ADDR_WIDTH'(1'b1);
    end else begin
      init_cnt_r <= init_cnt_r;
    end
  end

  assign init_active_s = (state_r == ARB_INIT);
  assign init_addr_s   = init_cnt_r;
  assign init_last_s   = (init_cnt_r == {RF_ADDR_WIDTH{1'b1}});
`else
  assign init_active_s = 1'b0;
  assign init_addr_s   = ADDR_ZERO;
  assign init_last_s   = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_INIT: begin
        if (init_last_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_INIT;
        end
      end
      ARB_IDLE: begin
        if (grant_s) begin
          state_nxt_s = spr_bus_we_i ? ARB_ACK : ARB_RD;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_RD:  state_nxt_s = ARB_ACK;
      ARB_ACK: state_nxt_s = ARB_IDLE;
      default: state_nxt_s = RESET_STATE;
    endcase
  end

  // response data: read data captured in RD, zero for a granted write
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= DATA_ZERO;
    end else if (state_r == ARB_RD) begin
      data_r <= rf_spr_rdat_i;
    end else if (grant_s && spr_bus_we_i) begin
      data_r <= DATA_ZERO;
    end else begin
      data_r <= data_r;
    end
  end

  // RF write port mux: clear sequence, then write-back, then SPR write
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = ADDR_ZERO;
    rf_wdata_o = DATA_ZERO;
    if (rst) begin
      rf_we_o    = 1'b0;
    end else if (init_active_s) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = init_addr_s;
    end else if (wb_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
    end else if (grant_s && spr_bus_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = spr_rf_addr_s;
      rf_wdata_o = spr_bus_dat_i;
    end else begin
      rf_we_o    = 1'b0;
    end
  end

  // SPR-side read request issued in the grant cycle
  always_comb begin
    rf_spr_re_o    = 1'b0;
    rf_spr_raddr_o = ADDR_ZERO;
    if (grant_s && !spr_bus_we_i) begin
      rf_spr_re_o    = 1'b1;
      rf_spr_raddr_o = spr_rf_addr_s;
    end else begin
      rf_spr_re_o    = 1'b0;
    end
  end

  // blocked cycles accumulate; any grant or absent hit restarts the count
  mor1kx_sat_counter #(
    .WIDTH (STARVE_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (blocked_s),
    .clr (grant_s || !gpr_hit_s),
    .sat (starve_sat_s)
  );

  assign spr_gpr_ack_o = (state_r == ARB_ACK);
  assign spr_gpr_dat_o = spr_gpr_ack_o ? data_r : DATA_ZERO;
  assign pipe_hold_o   = starve_sat_s;
  assign init_busy_o   = init_active_s;

endmodule

// File: tb/tb_mor1kx_rf_arbiter_marocchino.sv
// Self-checking bench for mor1kx_rf_arbiter_marocchino (default parameters).
// Expected RF writes and SPR acks are queued as stimulus is driven and
// compared by a monitor on the falling edge as the DUT produces them.
module tb_mor1kx_rf_arbiter_marocchino;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we_i;
  logic [AW-1:0] wb_waddr_i;
  logic [DW-1:0] wb_wdata_i;
  logic [15:0]   spr_bus_addr_i;
  logic          spr_bus_stb_i;
  logic          spr_bus_we_i;
  logic [DW-1:0] spr_bus_dat_i;
  logic          spr_gpr_ack_o;
  logic [DW-1:0] spr_gpr_dat_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_spr_re_o;
  logic [AW-1:0] rf_spr_raddr_o;
  logic [DW-1:0] rf_spr_rdat_i;
  logic          pipe_hold_o;
  logic          init_busy_o;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wr_q[$];
  logic [DW-1:0] ack_q[$];
  wr_t           mon_wr;
  logic [DW-1:0] mon_ack;
  logic [DW-1:0] rnd;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  mor1kx_rf_arbiter_marocchino dut (
    .clk            (clk),
    .rst            (rst),
    .wb_we_i        (wb_we_i),
    .wb_waddr_i     (wb_waddr_i),
    .wb_wdata_i     (wb_wdata_i),
    .spr_bus_addr_i (spr_bus_addr_i),
    .spr_bus_stb_i  (spr_bus_stb_i),
    .spr_bus_we_i   (spr_bus_we_i),
    .spr_bus_dat_i  (spr_bus_dat_i),
    .spr_gpr_ack_o  (spr_gpr_ack_o),
    .spr_gpr_dat_o  (spr_gpr_dat_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .rf_spr_re_o    (rf_spr_re_o),
    .rf_spr_raddr_o (rf_spr_raddr_o),
    .rf_spr_rdat_i  (rf_spr_rdat_i),
    .pipe_hold_o    (pipe_hold_o),
    .init_busy_o    (init_busy_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spr_drive(input logic stb, input logic we, input logic [15:0] a, input logic [31:0] d);
    spr_bus_stb_i  = stb;
    spr_bus_we_i   = we;
    spr_bus_addr_i = a;
    spr_bus_dat_i  = d;
  endtask

  task automatic wb_drive(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    wb_we_i    = we;
    wb_waddr_i = a;
    wb_wdata_i = d;
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic exp_init_clear();
    for (int i = 0; i < 32; i++) exp_wr(AW'(i), 32'h0);
  endtask

  // scoreboard monitor: every RF write and every ack must have been expected
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we_o) begin
        if (wr_q.size() == 0) begin
          check_val("rf_we_unexpected", {31'd0, rf_we_o}, 32'd0);
        end else begin
          mon_wr = wr_q.pop_front();
          check_val("rf_waddr", 32'(rf_waddr_o), 32'(mon_wr.addr));
          check_val("rf_wdata", rf_wdata_o, mon_wr.data);
        end
      end
      if (spr_gpr_ack_o) begin
        if (ack_q.size() == 0) begin
          check_val("ack_unexpected", {31'd0, spr_gpr_ack_o}, 32'd0);
        end else begin
          mon_ack = ack_q.pop_front();
          check_val("ack_dat", spr_gpr_dat_o, mon_ack);
        end
      end else begin
        check_val("dat_idle_zero", spr_gpr_dat_o, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    wb_drive(1'b0, 5'd0, 32'h0);
    rf_spr_rdat_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    // reset state while rst is held
    @(negedge clk);
    check_val("rst_rf_we",  {31'd0, rf_we_o},       32'd0);
    check_val("rst_ack",    {31'd0, spr_gpr_ack_o}, 32'd0);
    check_val("rst_dat",    spr_gpr_dat_o,          32'h0);
    check_val("rst_re",     {31'd0, rf_spr_re_o},   32'd0);
    check_val("rst_hold",   {31'd0, pipe_hold_o},   32'd0);
    tick();

`ifdef MOR1KX_RF_INIT_CLEAR_EN
    // clear sequence interrupted at cycle 10, then restarted from 0
    for (int i = 0; i < 10; i++) exp_wr(AW'(i), 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    exp_init_clear();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_val("init_busy_on", {31'd0, init_busy_o}, 32'd1);
    end
    @(negedge clk);
    check_val("init_busy_off", {31'd0, init_busy_o}, 32'd0);
    check_val("init_drained", 32'(wr_q.size()), 32'd0);
    tick();
`else
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_init_busy", {31'd0, init_busy_o}, 32'd0);
    check_val("idle_rf_we",     {31'd0, rf_we_o},     32'd0);
    tick();
`endif

    // SPR write, then a back-to-back write in the cycle after ack
    spr_drive(1'b1, 1'b1, 16'h0405, 32'hDEADBEEF);
    exp_wr(5'd5, 32'hDEADBEEF);
    ack_q.push_back(32'h0);
    @(negedge clk);
    check_val("wr_grant_we", {31'd0, rf_we_o}, 32'd1);
    tick();
    @(negedge clk);
    check_val("wr_ack_lat", {31'd0, spr_gpr_ack_o}, 32'd1);
    tick();
    spr_drive(1'b1, 1'b1, 16'h0406, 32'h0BADF00D);
    exp_wr(5'd6, 32'h0BADF00D);
    ack_q.push_back(32'h0);
    @(negedge clk);
    check_val("b2b_grant", {31'd0, rf_we_o}, 32'd1);
    tick();
    @(negedge clk);
    check_val("b2b_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // SPR read: data captured one cycle after the read strobe
    rf_spr_rdat_i = 32'hFFFF0000;
    spr_drive(1'b1, 1'b0, 16'h0403, 32'h0);
    ack_q.push_back(32'h12345678);
    @(negedge clk);
    check_val("rd_re",    {31'd0, rf_spr_re_o},  32'd1);
    check_val("rd_raddr", 32'(rf_spr_raddr_o),   32'd3);
    check_val("rd_no_we", {31'd0, rf_we_o},      32'd0);
    tick();
    rf_spr_rdat_i = 32'h12345678;
    @(negedge clk);
    check_val("rd_no_early_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    tick();
    rf_spr_rdat_i = 32'h0;
    @(negedge clk);
    check_val("rd_ack_lat", {31'd0, spr_gpr_ack_o}, 32'd1);
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // SPR write blocked by three write-back cycles
    spr_drive(1'b1, 1'b1, 16'h0407, 32'hAAAA5555);
    for (int k = 0; k < 3; k++) begin
      wb_drive(1'b1, AW'(10 + k), 32'h10000000 + 32'(k));
      exp_wr(AW'(10 + k), 32'h10000000 + 32'(k));
      @(negedge clk);
      check_val("blk_hold", {31'd0, pipe_hold_o},   32'd0);
      check_val("blk_ack",  {31'd0, spr_gpr_ack_o}, 32'd0);
      tick();
    end
    wb_drive(1'b0, 5'd0, 32'h0);
    exp_wr(5'd7, 32'hAAAA5555);
    ack_q.push_back(32'h0);
    @(negedge clk);
    check_val("blk_grant", {31'd0, rf_we_o},     32'd1);
    check_val("blk_hold4", {31'd0, pipe_hold_o}, 32'd0);
    tick();
    @(negedge clk);
    check_val("blk_ack4", {31'd0, spr_gpr_ack_o}, 32'd1);
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // starvation: pipe_hold after 15 blocked cycles, cleared after grant
    spr_drive(1'b1, 1'b0, 16'h0401, 32'h0);
    for (int k = 0; k < 15; k++) begin
      rnd = $urandom;
      wb_drive(1'b1, AW'(k), rnd);
      exp_wr(AW'(k), rnd);
      @(negedge clk);
      check_val("starve_no_hold", {31'd0, pipe_hold_o}, 32'd0);
      tick();
    end
    wb_drive(1'b1, 5'd20, 32'hCAFE0001);
    exp_wr(5'd20, 32'hCAFE0001);
    @(negedge clk);
    check_val("starve_hold_set", {31'd0, pipe_hold_o}, 32'd1);
    check_val("starve_wb_wins",  {31'd0, rf_spr_re_o}, 32'd0);
    tick();
    wb_drive(1'b0, 5'd0, 32'h0);
    ack_q.push_back(32'h5A5A1234);
    @(negedge clk);
    check_val("starve_grant",      {31'd0, rf_spr_re_o}, 32'd1);
    check_val("starve_hold_grant", {31'd0, pipe_hold_o}, 32'd1);
    tick();
    rf_spr_rdat_i = 32'h5A5A1234;
    @(negedge clk);
    check_val("starve_hold_clear", {31'd0, pipe_hold_o}, 32'd0);
    tick();
    rf_spr_rdat_i = 32'h0;
    @(negedge clk);
    check_val("starve_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // non-GPR SPR group: no ack, no RF activity
    spr_drive(1'b1, 1'b1, 16'h0805, 32'h11111111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("miss_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
      check_val("miss_we",  {31'd0, rf_we_o},       32'd0);
      check_val("miss_re",  {31'd0, rf_spr_re_o},   32'd0);
      tick();
    end
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // reset in the middle of a read abandons it without ack
    spr_drive(1'b1, 1'b0, 16'h0402, 32'h0);
    @(negedge clk);
    check_val("abort_grant", {31'd0, rf_spr_re_o}, 32'd1);
    tick();
    rf_spr_rdat_i = 32'h00000077;
    rst = 1'b1;
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    rf_spr_rdat_i = 32'h0;
`ifdef MOR1KX_RF_INIT_CLEAR_EN
    exp_init_clear();
`endif
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check_val("abort_no_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
      tick();
    end

    check_val("wr_q_empty",  32'(wr_q.size()),  32'd0);
    check_val("ack_q_empty", 32'(ack_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
